// File: rtl/top.sv
//==============================================================================
// Module      : top
// Description : Fixed 4-3-1 feed-forward network (ReLU hidden layer, linear
//               output) evaluated with a single serial multiply-accumulate
//               unit. Inputs, weights and biases are constant ROMs; the
//               result is computed once after reset and then held.
//
// Ports       : clk      - single clock, rising edge
//               reset    - synchronous, active-high
//               out      - signed Q8.8 network result (registered)
//               finished - high while out holds the final result (registered)
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module top #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic [DATA_W-1:0] out,
    output logic              finished
);

    localparam int ACC_W = 2 * DATA_W;

    // Saturation bounds expressed at the widened finalize width.
    localparam logic signed [ACC_W:0] c_sat_max =
        {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] c_sat_min =
        {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    localparam logic signed [DATA_W-1:0] c_b2 = 16'sh0040;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_L1_MAC = 3'd1,
        S_L1_FIN = 3'd2,
        S_L2_MAC = 3'd3,
        S_L2_FIN = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    //--------------------------------------------------------------------------
    // Constant ROMs
    //--------------------------------------------------------------------------
    function automatic logic signed [DATA_W-1:0] f_x(input logic [1:0] i);
        logic signed [DATA_W-1:0] v;
        case (i)
            2'd0:    v = 16'sh0100;
            2'd1:    v = 16'sh0200;
            2'd2:    v = 16'shFF00;
            default: v = 16'sh0080;
        endcase
        return v;
    endfunction

    function automatic logic signed [DATA_W-1:0] f_w1(input logic [1:0] j,
                                                      input logic [1:0] i);
        logic signed [DATA_W-1:0] v;
        case ({j, i})
            4'b00_00: v = 16'sh0100;
            4'b00_01: v = 16'sh0080;
            4'b01_10: v = 16'sh0100;
            4'b10_00: v = 16'sh0040;
            4'b10_01: v = 16'sh0040;
            4'b10_11: v = 16'sh0200;
            default:  v = 16'sh0000;
        endcase
        return v;
    endfunction

    function automatic logic signed [DATA_W-1:0] f_b1(input logic [1:0] j);
        return (j == 2'd2) ? 16'sh0080 : 16'sh0000;
    endfunction

    function automatic logic signed [DATA_W-1:0] f_w2(input logic [1:0] j);
        logic signed [DATA_W-1:0] v;
        case (j)
            2'd0:    v = 16'sh0100;
            2'd1:    v = 16'sh0300;
            default: v = 16'shFF80;
        endcase
        return v;
    endfunction

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    state_t                   r_state;
    logic signed [ACC_W-1:0]  r_acc;
    logic [1:0]               r_i;
    logic [1:0]               r_j;
    logic signed [DATA_W-1:0] r_h [0:2];
    logic [DATA_W-1:0]        r_out;
    logic                     r_finished;

    //--------------------------------------------------------------------------
    // Datapath: operand select, product, finalize
    //--------------------------------------------------------------------------
    logic signed [DATA_W-1:0] w_a;
    logic signed [DATA_W-1:0] w_b;
    logic signed [DATA_W-1:0] w_bias;
    logic signed [ACC_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]  w_prod_q;
    logic signed [ACC_W:0]    w_fin;
    logic signed [DATA_W-1:0] w_sat;

    always_comb begin
        w_a = '0;
        w_b = '0;
        case (r_state)
            S_L1_MAC: begin
                w_a = f_x(r_i);
                w_b = f_w1(r_j, r_i);
            end
            S_L2_MAC: begin
                case (r_j)
                    2'd0:    w_a = r_h[0];
                    2'd1:    w_a = r_h[1];
                    default: w_a = r_h[2];
                endcase
                w_b = f_w2(r_j);
            end
            default: ;
        endcase
    end

    assign w_prod   = w_a * w_b;
    // Rescale the Q16.16 product back to Q8.8 before accumulating.
    assign w_prod_q = w_prod >>> FRAC_W;

    assign w_bias = (r_state == S_L2_FIN) ? c_b2 : f_b1(r_j);

    // One extra bit so acc + bias cannot wrap before saturation.
    assign w_fin = {r_acc[ACC_W-1], r_acc}
                 + {{(ACC_W+1-DATA_W){w_bias[DATA_W-1]}}, w_bias};

    always_comb begin
        if (w_fin > c_sat_max) begin
            w_sat = c_sat_max[DATA_W-1:0];
        end else if (w_fin < c_sat_min) begin
            w_sat = c_sat_min[DATA_W-1:0];
        end else begin
            w_sat = w_fin[DATA_W-1:0];
        end
    end

    //--------------------------------------------------------------------------
    // Sequencer
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_h[0]     <= '0;
            r_h[1]     <= '0;
            r_h[2]     <= '0;
            r_out      <= '0;
            r_finished <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_acc   <= '0;
                    r_i     <= '0;
                    r_j     <= '0;
                    r_state <= S_L1_MAC;
                end
                S_L1_MAC: begin
                    r_acc <= r_acc + w_prod_q;
                    r_i   <= r_i + 2'd1;
                    if (r_i == 2'd3) begin
                        r_state <= S_L1_FIN;
                    end
                end
                S_L1_FIN: begin
                    // ReLU: negative pre-activations become zero.
                    r_h[r_j] <= w_sat[DATA_W-1] ? '0 : w_sat;
                    r_acc    <= '0;
                    r_i      <= '0;
                    if (r_j == 2'd2) begin
                        r_j     <= '0;
                        r_state <= S_L2_MAC;
                    end else begin
                        r_j     <= r_j + 2'd1;
                        r_state <= S_L1_MAC;
                    end
                end
                S_L2_MAC: begin
                    r_acc <= r_acc + w_prod_q;
                    if (r_j == 2'd2) begin
                        r_j     <= '0;
                        r_state <= S_L2_FIN;
                    end else begin
                        r_j <= r_j + 2'd1;
                    end
                end
                S_L2_FIN: begin
                    r_out      <= w_sat;
                    r_finished <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out      = r_out;
    assign finished = r_finished;

endmodule

`default_nettype wire

// File: tb/tb_top.sv
`default_nettype none

module tb_top;

    logic        clk;
    logic        reset;
    logic [15:0] out;
    logic        finished;

    int n_cmp = 0;
    int n_err = 0;

    top #(.DATA_W(16), .FRAC_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .out      (out),
        .finished (finished)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        int          edge_n;
        logic [15:0] exp_out;
        logic        exp_fin;
    } vec_t;

    vec_t vecs [0:10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Full computation after a release: 19 edges of zero outputs,
    // hidden layer visible at L2_MAC entry, result on edge 20.
    task automatic run_full(input string tag);
        for (int e = 1; e <= 19; e++) begin
            step();
            chk({tag, "_pre_out"}, 32'(out), 32'h0);
            chk({tag, "_pre_fin"}, 32'(finished), 32'h0);
            if (e == 16) begin
                chk({tag, "_h0"}, 32'(dut.r_h[0]), 32'h0200);
                chk({tag, "_h1"}, 32'(dut.r_h[1]), 32'h0000);
                chk({tag, "_h2"}, 32'(dut.r_h[2]), 32'h0240);
            end
        end
        step();
        chk({tag, "_e20_out"}, 32'(out), 32'h0120);
        chk({tag, "_e20_fin"}, 32'(finished), 32'h1);
    endtask

    initial begin
        int ec;

        vecs[0]  = '{1,  16'h0000, 1'b0};
        vecs[1]  = '{4,  16'h0000, 1'b0};
        vecs[2]  = '{5,  16'h0000, 1'b0};
        vecs[3]  = '{6,  16'h0000, 1'b0};
        vecs[4]  = '{11, 16'h0000, 1'b0};
        vecs[5]  = '{16, 16'h0000, 1'b0};
        vecs[6]  = '{17, 16'h0000, 1'b0};
        vecs[7]  = '{19, 16'h0000, 1'b0};
        vecs[8]  = '{20, 16'h0120, 1'b1};
        vecs[9]  = '{21, 16'h0120, 1'b1};
        vecs[10] = '{30, 16'h0120, 1'b1};

        // Reset held for several edges keeps outputs at zero.
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_out", 32'(out), 32'h0);
            chk("rst_fin", 32'(finished), 32'h0);
        end
        reset = 1'b0;

        // Table-driven first run, edges counted from release.
        ec = 0;
        for (int v = 0; v < 11; v++) begin
            while (ec < vecs[v].edge_n) begin
                step();
                ec++;
            end
            chk($sformatf("vec%0d_out", vecs[v].edge_n), 32'(out), 32'(vecs[v].exp_out));
            chk($sformatf("vec%0d_fin", vecs[v].edge_n), 32'(finished), 32'(vecs[v].exp_fin));
        end

        // Long hold in DONE: no recomputation, no glitches (~4000 ns).
        for (int k = 0; k < 200; k++) begin
            step();
            chk("hold_out", 32'(out), 32'h0120);
            chk("hold_fin", 32'(finished), 32'h1);
        end

        // Reset in DONE clears outputs on the next edge, then full recompute.
        reset = 1'b1;
        step();
        chk("done_rst_out", 32'(out), 32'h0);
        chk("done_rst_fin", 32'(finished), 32'h0);
        reset = 1'b0;
        run_full("after_done");

        // Abort mid-computation: reset sampled on the 10th edge after release.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
        end
        reset = 1'b1;
        step();
        chk("mid_rst_out", 32'(out), 32'h0);
        chk("mid_rst_fin", 32'(finished), 32'h0);
        reset = 1'b0;
        run_full("after_mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameters: DATA_W, default 16, datapath word width; FRAC_W, default 8, fractional bits (signed Q8.8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 out  output  16  signed Q8.8 network result; registered.
REQ-005 finished  output  1  high when out holds the valid final result; registered.
REQ-006 No other ports; inputs, weights and biases are internal constant ROMs.

Function
REQ-007 Network: 4 inputs -> 3 hidden neurons (ReLU) -> 1 linear output neuron, all values signed Q8.8.
REQ-008 Inputs x[0..3] SHALL be 0x0100, 0x0200, 0xFF00, 0x0080 (1.0, 2.0, -1.0, 0.5).
REQ-009 Hidden weights: h0 = [0x0100, 0x0080, 0, 0], bias 0; h1 = [0, 0, 0x0100, 0], bias 0; h2 = [0x0040, 0x0040, 0, 0x0200], bias 0x0080.
REQ-010 Output weights: [0x0100, 0x0300, 0xFF80] for h0..h2, bias 0x0040.
REQ-011 One serial MAC: 16x16 signed product (32-bit), arithmetic shift right by FRAC_W, added to a 32-bit signed accumulator; one product per cycle.
REQ-012 Neuron finalize: acc + (bias sign-extended), saturated to [0x8000, 0x7FFF]; hidden neurons then ReLU (negative -> 0); output neuron is not clamped.
REQ-013 FSM states: IDLE, L1_MAC, L1_FIN, L2_MAC, L2_FIN, DONE.
REQ-014 IDLE: one cycle, clears accumulator and indices, goes to L1_MAC.
REQ-015 L1_MAC: 4 cycles per hidden neuron (i = 0..3), then L1_FIN: 1 cycle writes h[j], clears acc; next neuron, or L2_MAC after j = 2.
REQ-016 L2_MAC: 3 cycles (h0..h2), then L2_FIN: 1 cycle loads out and sets finished, then DONE.
REQ-017 Latency: out and finished update on the 20th rising edge with reset low (1 + 3x5 + 4).
REQ-018 DONE: out and finished held constant indefinitely until reset; no recomputation.
REQ-019 out SHALL remain 0x0000 and finished 0 at all times before the L2_FIN edge.
REQ-020 Expected result: h = [0x0200, 0x0000, 0x0240]; out = 0x0120 (1.125).

Reset
REQ-021 reset high at a rising edge: state -> IDLE, acc, indices, h[] -> 0, out -> 0x0000, finished -> 0.
REQ-022 Reset asserted mid-computation or in DONE aborts and clears everything; computation restarts from IDLE on the first edge with reset low, full 20-cycle latency again.
REQ-023 Reset held multiple cycles keeps all outputs at reset values.

Verification
REQ-024 Reset held 1 cycle (20 ns period) -> out = 0x0000, finished = 0 while reset high and for 19 edges after release.
REQ-025 Release reset, count edges -> finished rises exactly on the 20th edge, out = 0x0120 on the same edge.
REQ-026 Run 4000 ns after release -> finished stays 1, out stays 0x0120, no glitches.
REQ-027 Reassert reset on the 10th edge after release for 1 cycle -> outputs 0/0; finished rises 20 edges after second release with out = 0x0120.
REQ-028 Reset asserted in DONE -> out = 0x0000, finished = 0 next edge; recompute yields 0x0120 after 20 edges.
REQ-029 Probe h[] in simulation at L2_MAC entry -> h0 = 0x0200, h1 = 0x0000 (ReLU clamp), h2 = 0x0240.
